// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input conditioner: coin FSM states,
// PS/2 scan codes, joystick bit positions and in0/in1 bit positions.
package arcade_input_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_LOCKOUT,
        COIN_RELEASE
    } coin_state_t;

    // Player-1 directions match on the low byte only (extended and plain codes alias)
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;

    localparam logic [8:0] SC_FIRE1_A  = 9'h029;
    localparam logic [8:0] SC_FIRE1_B  = 9'h014;
    localparam logic [8:0] SC_START1_A = 9'h005;
    localparam logic [8:0] SC_START1_B = 9'h016;
    localparam logic [8:0] SC_START2_A = 9'h006;
    localparam logic [8:0] SC_START2_B = 9'h01E;
    localparam logic [8:0] SC_COIN_A   = 9'h004;
    localparam logic [8:0] SC_COIN_B   = 9'h02E;
    localparam logic [8:0] SC_COIN_C   = 9'h036;
    localparam logic [8:0] SC_P2_UP    = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT  = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT = 9'h034;
    localparam logic [8:0] SC_FIRE2    = 9'h01C;

    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;
    localparam int unsigned JOY_COIN   = 7;

    localparam int unsigned IN_UP      = 0;
    localparam int unsigned IN_LEFT    = 1;
    localparam int unsigned IN_RIGHT   = 2;
    localparam int unsigned IN_DOWN    = 3;
    localparam int unsigned IN0_FIRE   = 4;
    localparam int unsigned IN0_COIN   = 5;
    localparam int unsigned IN1_START1 = 5;
    localparam int unsigned IN1_START2 = 6;

    typedef struct packed {
        logic up1;
        logic down1;
        logic left1;
        logic right1;
        logic fire1;
        logic start1;
        logic start2;
        logic coin;
        logic up2;
        logic down2;
        logic left2;
        logic right2;
        logic fire2;
    } key_state_t;

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 key event decoder: detects toggles of ps2_key[10] and tracks the
// pressed/released state of every mapped arcade key.
module ps2_key_decoder
    import arcade_input_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] ps2_key,
    output key_state_t  keys
);

    logic       toggle_q;
    logic       armed;
    logic       key_event;
    logic       pressed;
    logic [8:0] code;
    key_state_t keys_next;

    assign code      = ps2_key[8:0];
    assign pressed   = ps2_key[9];
    assign key_event = ps2_key[10] != toggle_q;

    // Apply the current event's code to a copy of the key state
    always_comb begin
        keys_next = keys;
        if (code[7:0] == SC_P1_UP) begin
            keys_next.up1 = pressed;
        end else if (code[7:0] == SC_P1_DOWN) begin
            keys_next.down1 = pressed;
        end else if (code[7:0] == SC_P1_LEFT) begin
            keys_next.left1 = pressed;
        end else if (code[7:0] == SC_P1_RIGHT) begin
            keys_next.right1 = pressed;
        end else begin
            case (code)
                SC_FIRE1_A, SC_FIRE1_B:          keys_next.fire1  = pressed;
                SC_START1_A, SC_START1_B:        keys_next.start1 = pressed;
                SC_START2_A, SC_START2_B:        keys_next.start2 = pressed;
                SC_COIN_A, SC_COIN_B, SC_COIN_C: keys_next.coin   = pressed;
                SC_P2_UP:                        keys_next.up2    = pressed;
                SC_P2_DOWN:                      keys_next.down2  = pressed;
                SC_P2_LEFT:                      keys_next.left2  = pressed;
                SC_P2_RIGHT:                     keys_next.right2 = pressed;
                SC_FIRE2:                        keys_next.fire2  = pressed;
                default:                         ;
            endcase
        end
    end

    // First cycle out of reset only samples the toggle bit, so a stale toggle is not an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
            armed    <= 1'b0;
            keys     <= '0;
        end else begin
            toggle_q <= ps2_key[10];
            armed    <= 1'b1;
            if (armed && key_event) begin
                keys <= keys_next;
            end
        end
    end

endmodule

// File: rtl/arcade_input_cond.sv
// Arcade input conditioner: merges PS/2 keys and joysticks into active-low
// in0/in1 bytes and shapes coins into frame-timed pulses.
// Define ARCADE_COIN_LOCKOUT_EN to add a post-pulse coin lockout period.
module arcade_input_cond
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 3,
    parameter int unsigned LOCK_FRAMES = 6
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    input  logic        vblank,
    input  logic        club,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic        coin_active
);

    key_state_t        keys;
    logic [4:0]        p1_joy;
    logic [4:0]        p2_joy;
    logic              up1, down1, left1, right1, fire1;
    logic              up2, down2, left2, right2, fire2;
    logic              start1, start2;
    logic              coin_req;
    logic              coin_req_q;
    logic              coin_edge;
    logic              vblank_q;
    logic              frame_tick;
    coin_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              coin_active_next;
    logic [7:0]        in0_act;
    logic [7:0]        in1_act;
    logic              unused_joy;

    assign unused_joy = ^{joy1[15:8], joy2[15:8]};

`ifndef ARCADE_COIN_LOCKOUT_EN
    localparam int unsigned LOCK_UNUSED = LOCK_FRAMES;
`endif

    ps2_key_decoder u_decoder (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .ps2_key (ps2_key),
        .keys    (keys)
    );

    // Shared-joystick mode feeds the OR of both sticks to both players
    assign p1_joy = club ? joy1[4:0] : (joy1[4:0] | joy2[4:0]);
    assign p2_joy = club ? joy2[4:0] : (joy1[4:0] | joy2[4:0]);

    assign up1    = keys.up1    | p1_joy[JOY_UP];
    assign down1  = keys.down1  | p1_joy[JOY_DOWN];
    assign left1  = keys.left1  | p1_joy[JOY_LEFT];
    assign right1 = keys.right1 | p1_joy[JOY_RIGHT];
    assign fire1  = keys.fire1  | p1_joy[JOY_FIRE];
    assign up2    = keys.up2    | p2_joy[JOY_UP];
    assign down2  = keys.down2  | p2_joy[JOY_DOWN];
    assign left2  = keys.left2  | p2_joy[JOY_LEFT];
    assign right2 = keys.right2 | p2_joy[JOY_RIGHT];
    assign fire2  = keys.fire2  | p2_joy[JOY_FIRE];
    assign start1 = keys.start1 | joy1[JOY_START1] | joy2[JOY_START1];
    assign start2 = keys.start2 | joy1[JOY_START2] | joy2[JOY_START2];
    assign coin_req = keys.coin | joy1[JOY_COIN] | joy2[JOY_COIN];

    // Edge history resets high so inputs already asserted at release give no edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            coin_req_q <= 1'b1;
            coin_edge  <= 1'b0;
            vblank_q   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            coin_req_q <= coin_req;
            coin_edge  <= coin_req & ~coin_req_q;
            vblank_q   <= vblank;
            frame_tick <= vblank & ~vblank_q;
        end
    end

    // Coin FSM next state; edges outside IDLE are dropped
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            COIN_IDLE: begin
                if (coin_edge) begin
                    state_next = COIN_PULSE;
                    cnt_next   = CNT_W'(COIN_FRAMES);
                end
            end
            COIN_PULSE: begin
                if (frame_tick) begin
                    if (cnt == CNT_W'(1)) begin
`ifdef ARCADE_COIN_LOCKOUT_EN
                        state_next = COIN_LOCKOUT;
                        cnt_next   = CNT_W'(LOCK_FRAMES);
`else
                        state_next = COIN_RELEASE;
                        cnt_next   = '0;
`endif
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            COIN_LOCKOUT: begin
                if (frame_tick) begin
                    if (cnt == CNT_W'(1)) begin
                        state_next = COIN_RELEASE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            COIN_RELEASE: begin
                if (!coin_req) begin
                    state_next = COIN_IDLE;
                end
            end
            default: begin
                state_next = COIN_IDLE;
                cnt_next   = '0;
            end
        endcase
        coin_active_next = (state_next == COIN_PULSE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= COIN_IDLE;
            cnt         <= '0;
            coin_active <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            coin_active <= coin_active_next;
        end
    end

    // Active-high images of the output bytes; unused bit positions read as set
    always_comb begin
        in0_act           = 8'hC0;
        in0_act[IN_UP]    = up1;
        in0_act[IN_LEFT]  = left1;
        in0_act[IN_RIGHT] = right1;
        in0_act[IN_DOWN]  = down1;
        in0_act[IN0_FIRE] = fire1;
        in0_act[IN0_COIN] = coin_active;

        in1_act             = 8'h90;
        in1_act[IN_UP]      = up2;
        in1_act[IN_LEFT]    = left2;
        in1_act[IN_RIGHT]   = right2;
        in1_act[IN_DOWN]    = down2;
        in1_act[IN1_START1] = start1;
        in1_act[IN1_START2] = start2;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            in0 <= 8'hFF;
            in1 <= 8'hFF;
        end else begin
            in0 <= ~in0_act;
            in1 <= ~in1_act;
        end
    end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Testbench for arcade_input_cond: scoreboard of expected {coin_active,in0,in1}
// per scenario; expectations adapt to ARCADE_COIN_LOCKOUT_EN.
module tb_arcade_input_cond;

    logic        CLK;
    logic        RESET_N;
    logic [10:0] ps2_key;
    logic [15:0] joy1;
    logic [15:0] joy2;
    logic        vblank;
    logic        club;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic        coin_active;

`ifdef ARCADE_COIN_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [9:0] KEY_SEQ [0:25] = '{
        10'h275, 10'h075, 10'h372, 10'h26B, 10'h374, 10'h229, 10'h014,
        10'h205, 10'h21E, 10'h22D, 10'h22B, 10'h223, 10'h234, 10'h21C,
        10'h329, 10'h2FF, 10'h172, 10'h06B, 10'h074, 10'h016, 10'h006,
        10'h02D, 10'h02B, 10'h023, 10'h034, 10'h01C
    };

    int          tests;
    int          fails;
    logic [12:0] mk;
    logic        tog;
    logic [16:0] exp_q [$];
    logic [16:0] got;
    logic [16:0] e;

    arcade_input_cond #(
        .COIN_FRAMES (3),
        .LOCK_FRAMES (6)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .ps2_key     (ps2_key),
        .joy1        (joy1),
        .joy2        (joy2),
        .vblank      (vblank),
        .club        (club),
        .in0         (in0),
        .in1         (in1),
        .coin_active (coin_active)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame();
        vblank = 1'b1;
        step(2);
        vblank = 1'b0;
        step(2);
    endtask

    // Bench key index: 0 up1,1 down1,2 left1,3 right1,4 fire1,5 start1,6 start2,
    // 7 coin,8 up2,9 down2,10 left2,11 right2,12 fire2
    function automatic int code_idx(input logic [8:0] c);
        case (c[7:0])
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: ;
        endcase
        case (c)
            9'h029, 9'h014:         return 4;
            9'h005, 9'h016:         return 5;
            9'h006, 9'h01E:         return 6;
            9'h004, 9'h02E, 9'h036: return 7;
            9'h02D:                 return 8;
            9'h02B:                 return 9;
            9'h023:                 return 10;
            9'h034:                 return 11;
            9'h01C:                 return 12;
            default:                return -1;
        endcase
    endfunction

    function automatic logic [16:0] model(input logic coin);
        logic [7:0] p1, p2, a0, a1;
        p1 = club ? joy1[7:0] : (joy1[7:0] | joy2[7:0]);
        p2 = club ? joy2[7:0] : (joy1[7:0] | joy2[7:0]);
        a0 = {1'b1, 1'b1, coin, mk[4] | p1[4], mk[1] | p1[2], mk[3] | p1[0],
              mk[2] | p1[1], mk[0] | p1[3]};
        a1 = {1'b1, mk[6] | joy1[6] | joy2[6], mk[5] | joy1[5] | joy2[5], 1'b1,
              mk[9] | p2[2], mk[11] | p2[0], mk[10] | p2[1], mk[8] | p2[3]};
        return {coin, ~a0, ~a1};
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0;
        step(2);
        exp_q.push_back(17'h0FFFF);
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL reset_hold got %h exp %h", got, e);
        end
        RESET_N = 1'b1;
        step(2);
        exp_q.push_back(model(1'b0));
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL reset_release got %h exp %h", got, e);
        end
    endtask

    task automatic test_keys();
        int idx;
        for (int i = 0; i < 26; i++) begin
            exp_q.push_back(model(1'b0));
            tog = ~tog;
            ps2_key = {tog, KEY_SEQ[i]};
            idx = code_idx(KEY_SEQ[i][8:0]);
            if (idx >= 0) mk[idx] = KEY_SEQ[i][9];
            exp_q.push_back(model(1'b0));
            step(1);
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL key_latency i=%0d got %h exp %h", i, got, e);
            end
            step(1);
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL key_state i=%0d got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_joy_club();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                club = 1'b0; joy1 = 16'h0000; joy2 = 16'h0008;
            end else if (i == 1) begin
                club = 1'b1; joy1 = 16'h0000; joy2 = 16'h0008;
            end else begin
                club = 1'($urandom_range(0, 1));
                joy1 = 16'($urandom) & 16'hFF7F;
                joy2 = 16'($urandom) & 16'hFF7F;
            end
            exp_q.push_back(model(1'b0));
            step(1);
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL joy_club i=%0d club=%0b got %h exp %h", i, club, got, e);
            end
        end
        club = 1'b1;
        joy1 = '0;
        joy2 = '0;
        step(2);
    endtask

    task automatic test_coin_pulse();
        joy1 = 16'h0080;
        step(3);
        exp_q.push_back(model(1'b1));
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL coin_start got %h exp %h", got, e);
        end
        for (int f = 1; f <= 10; f++) begin
            frame();
            exp_q.push_back(model(f < 3));
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL coin_frame f=%0d got %h exp %h", f, got, e);
            end
        end
        joy1 = '0;
        step(2);
    endtask

    task automatic test_lockout();
        joy1 = 16'h0080;
        step(3);
        exp_q.push_back(model(1'b1));
        for (int f = 1; f <= 3; f++) begin
            if (f > 1) exp_q.push_back(model(1'b1));
            if (f > 1) frame();
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL lock_first f=%0d got %h exp %h", f, got, e);
            end
        end
        frame();
        exp_q.push_back(model(1'b0));
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL lock_first_end got %h exp %h", got, e);
        end
        joy1 = '0;
        step(2);
        frame();
        frame();
        joy1 = 16'h0080;
        step(3);
        exp_q.push_back(model(!LOCK_EN));
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL lock_early_edge got %h exp %h", got, e);
        end
        joy1 = '0;
        step(2);
        for (int f = 1; f <= 4; f++) begin
            frame();
            exp_q.push_back(model(LOCK_EN ? 1'b0 : (f < 3)));
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL lock_wait f=%0d got %h exp %h", f, got, e);
            end
        end
        joy1 = 16'h0080;
        step(3);
        exp_q.push_back(model(1'b1));
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL lock_late_edge got %h exp %h", got, e);
        end
        for (int f = 1; f <= 3; f++) begin
            frame();
            exp_q.push_back(model(f < 3));
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL lock_second f=%0d got %h exp %h", f, got, e);
            end
        end
        joy1 = '0;
        step(2);
        repeat (6) frame();
    endtask

    task automatic test_reset_mid_pulse();
        joy1 = 16'h0080;
        step(3);
        frame();
        exp_q.push_back(model(1'b1));
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL mid_pulse_pre got %h exp %h", got, e);
        end
        tog = 1'b1;
        ps2_key = {1'b1, 10'h275};
        #2;
        RESET_N = 1'b0;
        #1;
        exp_q.push_back(17'h0FFFF);
        got = {coin_active, in0, in1};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL mid_pulse_reset got %h exp %h", got, e);
        end
        mk = '0;
        step(2);
        RESET_N = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            frame();
            exp_q.push_back(model(1'b0));
            got = {coin_active, in0, in1};
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL post_reset f=%0d got %h exp %h", f, got, e);
            end
        end
        joy1 = '0;
        step(2);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        mk      = '0;
        tog     = 1'b0;
        RESET_N = 1'b0;
        ps2_key = '0;
        joy1    = '0;
        joy2    = '0;
        vblank  = 1'b0;
        club    = 1'b1;
        test_reset();
        test_keys();
        test_joy_club();
        test_coin_pulse();
        test_lockout();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arcade_input_cond.md
ARCADE_INPUT_COND -- requirements
Module: arcade_input_cond

Interface
REQ-001 SHALL have parameter COIN_FRAMES, default 3, coin pulse length in frames (legal 1..15).
REQ-002 SHALL have parameter LOCK_FRAMES, default 6, post-pulse coin lockout length in frames (legal 1..15).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_key  input  11  [10] event toggle, [9] pressed, [8:0] scan code.
REQ-006 SHALL have port joy1  input  16  player-1 joystick word, active-high.
REQ-007 SHALL have port joy2  input  16  player-2 joystick word, active-high.
REQ-008 SHALL have port vblank  input  1  video vertical blank; its rising edge is the frame tick.
REQ-009 SHALL have port club  input  1  1 = separate player inputs, 0 = joy1|joy2 feed both players.
REQ-010 SHALL have port in0  output  8  active-low player-1/system input byte.
REQ-011 SHALL have port in1  output  8  active-low player-2/start input byte.
REQ-012 SHALL have port coin_active  output  1  high while coin pulse is asserted.

Function
REQ-013 SHALL detect a key event when ps2_key[10] differs from its registered copy; key state updates 1 cycle later.
REQ-014 SHALL decode codes ignoring bit 8 for 75/72/6B/74 (p1 up/down/left/right); exact 029/014 fire1, 005/016 start1, 006/01E start2, 004/02E/036 coin, 02D/02B/023/034 p2 up/down/left/right, 01C fire2; state = ps2_key[9]; other codes ignored.
REQ-015 SHALL form per-player controls as key OR joystick (bit3 up, bit2 down, bit1 left, bit0 right, bit4 fire, bit5 start1, bit6 start2, bit7 coin); with club=0 both players use joy1|joy2.
REQ-016 SHALL derive coin_req = coin keys | joy1[7] | joy2[7] and register its rising edge.
REQ-017 SHALL run coin FSM IDLE -> PULSE on coin_req rising edge, loading counter with COIN_FRAMES.
REQ-018 SHALL in PULSE decrement on each frame tick; on tick with counter 1 go to LOCKOUT loading LOCK_FRAMES.
REQ-019 SHALL in LOCKOUT decrement on each frame tick; on tick with counter 1 go to RELEASE.
REQ-020 SHALL in RELEASE return to IDLE on the first cycle coin_req is low.
REQ-021 SHALL ignore coin_req edges outside IDLE (no queuing).
REQ-022 SHALL not decrement in the cycle PULSE is entered even if a frame tick coincides.
REQ-023 SHALL assert coin_active exactly while state is PULSE.
REQ-024 SHALL register in0 = ~{1,1,coin_active,fire1,down1,right1,left1,up1} and in1 = ~{1,start2,start1,1,down2,right2,left2,up2}; 1 cycle latency from internal state.

Reset
REQ-025 SHALL on RESET_N low force in0=8'hFF, in1=8'hFF, coin_active=0, FSM IDLE, counter 0, all key state 0.
REQ-026 SHALL on the first cycle after reset capture ps2_key[10] without decoding, so no spurious event occurs.
REQ-027 SHALL abort any in-progress pulse/lockout on reset, with no coin pulse after release.

Configuration
REQ-028 SHALL with ARCADE_COIN_LOCKOUT_EN defined implement LOCKOUT as in REQ-018/019.
REQ-029 SHALL without ARCADE_COIN_LOCKOUT_EN go PULSE -> RELEASE directly; LOCK_FRAMES unused.

Structure
REQ-030 SHALL place coin FSM state enum, scan-code constants and in0/in1 bit indices in package arcade_input_pkg.
REQ-031 SHALL implement scan-code decoding (REQ-013/014/026) in sub-module ps2_key_decoder.

Verification
REQ-032 SHALL cover: toggle ps2_key with 0x275 pressed -> in0[0]=0 two cycles later; toggle with 0x075 released -> in0[0]=1.
REQ-033 SHALL cover: joy1[7] held 10 frames, COIN_FRAMES=3 -> in0[5] low exactly 3 frame ticks, one pulse only until release.
REQ-034 SHALL cover: lockout enabled, LOCK_FRAMES=6, second coin edge 2 frames after pulse end -> ignored; edge after 6 frames -> new pulse.
REQ-035 SHALL cover: club=0, joy2[3]=1 -> in0[0]=0 and in1[0]=0; club=1 -> only in1[0]=0.
REQ-036 SHALL cover: RESET_N low mid-PULSE with ps2_key[10]=1 -> outputs 8'hFF immediately, no key event or pulse after release.
